pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register, the generalised successor of the fixed MEM/WB latch. It carries LANES parallel instruction slots, each with a payload and per-field write enables, from one pipeline stage to the next. It obeys the core's 6-bit stall vector and the exception flush, and adds per-lane kill, valid gating of write enables, and saturating hold/bubble/flush performance counters. Flush is applied uniformly to every field, so no payload field such as HI/LO escapes a flush.

---
 rtl/pipe_stage_reg.sv | 162 ++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: LANES instruction slots with valid-gated write enables,
// stall/flush/kill control and saturating hold/bubble/flush counters.
module pipe_stage_reg #(
    parameter int LANES      = 1,
    parameter int DATA_W     = 32,
    parameter int WE_W       = 4,
    parameter int STALL_W    = 6,
    parameter int STAGE      = 4,
    parameter int CNT_W      = 16,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_W-1:0]      stall,
    input  logic                    flush,
    input  logic [LANES-1:0]        kill_mask,
    input  logic [LANES-1:0]        in_valid,
    input  logic [LANES*WE_W-1:0]   in_we,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic                    cnt_clr,
    output logic [LANES-1:0]        out_valid,
    output logic [LANES*WE_W-1:0]   out_we,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]        hold_cnt,
    output logic [CNT_W-1:0]        bubble_cnt,
    output logic [CNT_W-1:0]        flush_cnt
);

    typedef enum logic [1:0] {
        ACT_ADVANCE = 2'd0,
        ACT_HOLD    = 2'd1,
        ACT_BUBBLE  = 2'd2,
        ACT_FLUSH   = 2'd3
    } act_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic                    us_s;
    logic                    ds_s;
    act_e                    act_s;
    logic [LANES-1:0]        valid_d, valid_q;
    logic [LANES*WE_W-1:0]   we_d, we_q;
    logic [LANES*DATA_W-1:0] data_d, data_q;
    logic [CNT_W-1:0]        hold_d, hold_q;
    logic [CNT_W-1:0]        bubble_d, bubble_q;
    logic [CNT_W-1:0]        flush_d, flush_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (c == CNT_MAX) begin
            sat_inc = c;
        end else begin
            sat_inc = c + CNT_W'(1'b1);
        end
    endfunction

    assign us_s = stall[STAGE];

    // The last stage in the stall vector has no downstream stage to wait on.
    generate
        if (STAGE < STALL_W - 1) begin : g_ds
            assign ds_s = stall[STAGE+1];
        end else begin : g_no_ds
            assign ds_s = 1'b0;
        end
    endgenerate

    // Per-edge action, flush first, then bubble/hold from the stall pair.
    always_comb begin
        act_s = ACT_ADVANCE;
        if (flush) begin
            act_s = ACT_FLUSH;
        end else if (us_s && !ds_s) begin
            act_s = ACT_BUBBLE;
        end else if (us_s) begin
            act_s = ACT_HOLD;
        end else begin
            act_s = ACT_ADVANCE;
        end
    end

    // Datapath next state; write enables are always gated by the lane's valid.
    always_comb begin
        valid_d = valid_q;
        we_d    = we_q;
        data_d  = data_q;
        case (act_s)
            ACT_FLUSH, ACT_BUBBLE: begin
                valid_d = {LANES{1'b0}};
                we_d    = {(LANES*WE_W){1'b0}};
                if (CLEAR_DATA) begin
                    data_d = {(LANES*DATA_W){1'b0}};
                end else begin
                    data_d = data_q;
                end
            end
            ACT_HOLD: begin
                valid_d = valid_q;
                we_d    = we_q;
                data_d  = data_q;
            end
            ACT_ADVANCE: begin
                for (int i = 0; i < LANES; i++) begin
                    valid_d[i]             = in_valid[i] & ~kill_mask[i];
                    we_d[i*WE_W +: WE_W]   = in_we[i*WE_W +: WE_W] & {WE_W{valid_d[i]}};
                end
                data_d = in_data;
            end
            default: begin
                valid_d = {LANES{1'b0}};
                we_d    = {(LANES*WE_W){1'b0}};
                data_d  = data_q;
            end
        endcase
    end

    // Counter next state; a clear wins over any increment in the same cycle.
    always_comb begin
        hold_d   = hold_q;
        bubble_d = bubble_q;
        flush_d  = flush_q;
        if (cnt_clr) begin
            hold_d   = {CNT_W{1'b0}};
            bubble_d = {CNT_W{1'b0}};
            flush_d  = {CNT_W{1'b0}};
        end else begin
            case (act_s)
                ACT_FLUSH:   flush_d  = sat_inc(flush_q);
                ACT_BUBBLE:  bubble_d = sat_inc(bubble_q);
                ACT_HOLD:    hold_d   = sat_inc(hold_q);
                ACT_ADVANCE: hold_d   = hold_q;
                default:     hold_d   = hold_q;
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q  <= {LANES{1'b0}};
            we_q     <= {(LANES*WE_W){1'b0}};
            data_q   <= {(LANES*DATA_W){1'b0}};
            hold_q   <= {CNT_W{1'b0}};
            bubble_q <= {CNT_W{1'b0}};
            flush_q  <= {CNT_W{1'b0}};
        end else begin
            valid_q  <= valid_d;
            we_q     <= we_d;
            data_q   <= data_d;
            hold_q   <= hold_d;
            bubble_q <= bubble_d;
            flush_q  <= flush_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_we     = we_q;
    assign out_data   = data_q;
    assign hold_cnt   = hold_q;
    assign bubble_cnt = bubble_q;
    assign flush_cnt  = flush_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a default instance, a 2-lane CLEAR_DATA=0 / CNT_W=4
// instance, and a last-stage (STAGE=5) instance sharing the default instance's inputs.
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [5:0]  a_stall;
    logic        a_flush, a_kill, a_valid, a_clr;
    logic [3:0]  a_we;
    logic [31:0] a_data;
    logic        a_ov;
    logic [3:0]  a_owe;
    logic [31:0] a_od;
    logic [15:0] a_hold, a_bub, a_fl;

    logic [5:0]  b_stall;
    logic        b_flush, b_clr;
    logic [1:0]  b_kill, b_valid;
    logic [7:0]  b_we;
    logic [63:0] b_data;
    logic [1:0]  b_ov;
    logic [7:0]  b_owe;
    logic [63:0] b_od;
    logic [3:0]  b_hold, b_bub, b_fl;

    logic        c_ov;
    logic [3:0]  c_owe;
    logic [31:0] c_od;
    logic [15:0] c_hold, c_bub, c_fl;

    int checks   = 0;
    int failures = 0;

    pipe_stage_reg dut_a (
        .clk(clk), .rst(rst), .stall(a_stall), .flush(a_flush), .kill_mask(a_kill),
        .in_valid(a_valid), .in_we(a_we), .in_data(a_data), .cnt_clr(a_clr),
        .out_valid(a_ov), .out_we(a_owe), .out_data(a_od),
        .hold_cnt(a_hold), .bubble_cnt(a_bub), .flush_cnt(a_fl)
    );

    pipe_stage_reg #(.LANES(2), .CLEAR_DATA(1'b0), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .stall(b_stall), .flush(b_flush), .kill_mask(b_kill),
        .in_valid(b_valid), .in_we(b_we), .in_data(b_data), .cnt_clr(b_clr),
        .out_valid(b_ov), .out_we(b_owe), .out_data(b_od),
        .hold_cnt(b_hold), .bubble_cnt(b_bub), .flush_cnt(b_fl)
    );

    pipe_stage_reg #(.STAGE(5)) dut_c (
        .clk(clk), .rst(rst), .stall(a_stall), .flush(a_flush), .kill_mask(a_kill),
        .in_valid(a_valid), .in_we(a_we), .in_data(a_data), .cnt_clr(a_clr),
        .out_valid(c_ov), .out_we(c_owe), .out_data(c_od),
        .hold_cnt(c_hold), .bubble_cnt(c_bub), .flush_cnt(c_fl)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        a_stall = 6'b0; a_flush = 1'b0; a_kill = 1'b0; a_valid = 1'b0; a_clr = 1'b0;
        a_we = 4'h0; a_data = 32'h0;
        b_stall = 6'b0; b_flush = 1'b0; b_clr = 1'b0; b_kill = 2'b0; b_valid = 2'b0;
        b_we = 8'h0; b_data = 64'h0;
        #12;
        check_eq("rst_valid", a_ov, 1'b0);
        check_eq("rst_data", a_od, 32'h0);
        rst = 1'b1;

        // capture then hold, so there is live state and a nonzero counter to reset
        a_valid = 1'b1; a_data = 32'hAAAA5555; a_we = 4'b0011;
        tick();
        check_eq("cap0_data", a_od, 32'hAAAA5555);
        check_eq("cap0_valid", a_ov, 1'b1);
        a_stall = 6'b111111;
        tick();
        check_eq("hold0_cnt", a_hold, 16'd1);
        check_eq("hold0_valid", a_ov, 1'b1);

        // asynchronous reset mid-cycle
        #2;
        rst = 1'b0;
        #1;
        check_eq("arst_valid", a_ov, 1'b0);
        check_eq("arst_we", a_owe, 4'h0);
        check_eq("arst_data", a_od, 32'h0);
        check_eq("arst_hold", a_hold, 16'd0);
        rst = 1'b1;

        a_stall = 6'b0; a_valid = 1'b1; a_data = 32'hDEADBEEF; a_we = 4'b1011;
        tick();
        check_eq("adv_data", a_od, 32'hDEADBEEF);
        check_eq("adv_we", a_owe, 4'b1011);
        check_eq("adv_valid", a_ov, 1'b1);

        // hold for two cycles with changed inputs
        a_stall = 6'b111111; a_valid = 1'b0; a_data = 32'h0; a_we = 4'h0;
        tick();
        check_eq("hold1_data", a_od, 32'hDEADBEEF);
        tick();
        check_eq("hold2_data", a_od, 32'hDEADBEEF);
        check_eq("hold2_we", a_owe, 4'b1011);
        check_eq("hold2_valid", a_ov, 1'b1);
        check_eq("hold2_cnt", a_hold, 16'd2);

        // flush beats a full stall
        a_flush = 1'b1;
        tick();
        check_eq("fl_valid", a_ov, 1'b0);
        check_eq("fl_we", a_owe, 4'h0);
        check_eq("fl_data", a_od, 32'h0);
        check_eq("fl_cnt", a_fl, 16'd1);
        check_eq("fl_hold", a_hold, 16'd2);
        a_flush = 1'b0;

        // downstream stalled but own stage free still advances
        a_stall = 6'b100000; a_valid = 1'b1; a_data = 32'h11112222; a_we = 4'b0101;
        tick();
        check_eq("dsonly_data", a_od, 32'h11112222);
        check_eq("dsonly_we", a_owe, 4'b0101);

        a_stall = 6'b011111;
        tick();
        check_eq("bub1_data", a_od, 32'h0);
        tick();
        tick();
        check_eq("bub3_cnt", a_bub, 16'd3);
        check_eq("bub3_valid", a_ov, 1'b0);
        check_eq("bub3_we", a_owe, 4'h0);

        a_stall = 6'b0; a_valid = 1'b0; a_we = 4'hF; a_data = 32'hCAFEF00D;
        tick();
        check_eq("gate_we", a_owe, 4'h0);
        check_eq("gate_data", a_od, 32'hCAFEF00D);

        a_valid = 1'b1; a_kill = 1'b1;
        tick();
        check_eq("kill_valid", a_ov, 1'b0);
        check_eq("kill_we", a_owe, 4'h0);
        a_kill = 1'b0;

        // flush together with counter clear
        a_flush = 1'b1; a_clr = 1'b1;
        tick();
        check_eq("flclr_fl", a_fl, 16'd0);
        check_eq("flclr_bub", a_bub, 16'd0);
        check_eq("flclr_hold", a_hold, 16'd0);
        check_eq("flclr_valid", a_ov, 1'b0);
        a_flush = 1'b0; a_clr = 1'b0;

        // last-stage instance: full stall is a bubble there, a hold for STAGE=4
        a_stall = 6'b0; a_valid = 1'b1; a_we = 4'h3; a_data = 32'h55AA55AA;
        tick();
        check_eq("c_adv_valid", c_ov, 1'b1);
        a_stall = 6'b111111;
        tick();
        tick();
        check_eq("c_bub_valid", c_ov, 1'b0);
        check_eq("c_bub_cnt", c_bub, 16'd2);
        check_eq("c_hold_cnt", c_hold, 16'd0);
        check_eq("a_hold_cnt", a_hold, 16'd2);

        // two-lane instance: per-lane kill
        b_valid = 2'b11; b_kill = 2'b10; b_we = 8'hFF; b_data = 64'hBBBB0002_AAAA0001;
        tick();
        check_eq("b_kill_valid", b_ov, 2'b01);
        check_eq("b_kill_we", b_owe, 8'h0F);
        check_eq("b_kill_data", b_od, 64'hBBBB0002_AAAA0001);

        b_kill = 2'b00; b_valid = 2'b01; b_we = 8'h03; b_data = 64'h00000000_12345678;
        tick();
        check_eq("b_cap_we", b_owe, 8'h03);
        b_stall = 6'b011111;
        tick();
        check_eq("b_bub_data", b_od, 64'h00000000_12345678);
        check_eq("b_bub_valid", b_ov, 2'b00);
        check_eq("b_bub_we", b_owe, 8'h00);
        check_eq("b_bub_cnt", b_bub, 4'd1);

        b_stall = 6'b0; b_valid = 2'b00; b_we = 8'hFF;
        tick();
        check_eq("b_gate_we", b_owe, 8'h00);

        b_stall = 6'b011111;
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        check_eq("b_sat_cnt", b_bub, 4'd15);
        b_clr = 1'b1;
        tick();
        check_eq("b_clr_cnt", b_bub, 4'd0);
        b_clr = 1'b0;
        tick();
        check_eq("b_after_clr", b_bub, 4'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
